// File: rtl/conv_pe_sequencer.sv
// Strobe sequencer for the Sub_top_CONV PE array: cal_start, PE_reset and PE_finish per OFM pixel,
// with OFM-writer back-pressure inserted ahead of every PE_finish.
module conv_pe_sequencer #(
   parameter int NUM_PE      = 16,
   parameter int START_DELAY = 3,
   parameter int PIX_W       = 16,
   parameter int ACC_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [PIX_W-1:0]  cfg_num_pixels,
   input  logic [ACC_W-1:0]  cfg_acc_cycles,
   input  logic              ofm_ready,
   output logic              cal_start,
   output logic [NUM_PE-1:0] PE_reset,
   output logic [NUM_PE-1:0] PE_finish,
   output logic              busy,
   output logic              done,
   output logic [PIX_W-1:0]  pixel_idx
);

   localparam int PCW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_RST,
      S_ACC,
      S_HOLD,
      S_FIN,
      S_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [PIX_W-1:0]   num_pix_reg, num_pix_next;
   logic [ACC_W-1:0]   acc_cyc_reg, acc_cyc_next;
   logic [ACC_W-1:0]   acc_cnt_reg, acc_cnt_next;
   logic [PCW-1:0]     prime_cnt_reg, prime_cnt_next;
   logic [PIX_W-1:0]   pix_reg, pix_next;

   logic               cal_start_reg;
   logic               pe_reset_reg;
   logic               pe_finish_reg;
   logic               busy_reg;
   logic               done_reg;

   always_comb begin
      state_next     = state_reg;
      num_pix_next   = num_pix_reg;
      acc_cyc_next   = acc_cyc_reg;
      acc_cnt_next   = acc_cnt_reg;
      prime_cnt_next = prime_cnt_reg;
      pix_next       = pix_reg;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               num_pix_next   = cfg_num_pixels;
               acc_cyc_next   = cfg_acc_cycles;
               prime_cnt_next = '0;
               pix_next       = '0;
               // An empty pass still reports completion, but never touches the array.
               state_next     = (cfg_num_pixels == '0) ? S_DONE : S_PRIME;
            end
         end

         S_PRIME: begin
            if (prime_cnt_reg == PCW'(START_DELAY - 1)) begin
               state_next = S_RST;
            end else begin
               prime_cnt_next = prime_cnt_reg + PCW'(1);
            end
         end

         S_RST: begin
            acc_cnt_next = '0;
            if (acc_cyc_reg != '0) begin
               state_next = S_ACC;
            end else begin
               state_next = ofm_ready ? S_FIN : S_HOLD;
            end
         end

         S_ACC: begin
            if (acc_cnt_reg == acc_cyc_reg - ACC_W'(1)) begin
               state_next = ofm_ready ? S_FIN : S_HOLD;
            end else begin
               acc_cnt_next = acc_cnt_reg + ACC_W'(1);
            end
         end

         S_HOLD: begin
            if (ofm_ready) begin
               state_next = S_FIN;
            end
         end

         S_FIN: begin
            // num_pix_reg is non-zero here, so the subtraction cannot wrap.
            if (pix_reg == num_pix_reg - PIX_W'(1)) begin
               state_next = S_DONE;
            end else begin
               pix_next   = pix_reg + PIX_W'(1);
               state_next = S_RST;
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
            pix_next   = '0;
         end

         default: begin
            state_next = S_IDLE;
            pix_next   = '0;
         end
      endcase

      if (abort && (state_reg != S_IDLE)) begin
         state_next = S_IDLE;
         pix_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         num_pix_reg   <= '0;
         acc_cyc_reg   <= '0;
         acc_cnt_reg   <= '0;
         prime_cnt_reg <= '0;
         pix_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         num_pix_reg   <= num_pix_next;
         acc_cyc_reg   <= acc_cyc_next;
         acc_cnt_reg   <= acc_cnt_next;
         prime_cnt_reg <= prime_cnt_next;
         pix_reg       <= pix_next;
      end
   end

   // Outputs are decoded from the next state so each strobe is a flop aligned with its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cal_start_reg <= 1'b0;
         pe_reset_reg  <= 1'b0;
         pe_finish_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         cal_start_reg <= (state_next == S_PRIME) || (state_next == S_RST) ||
                          (state_next == S_ACC)   || (state_next == S_HOLD) ||
                          (state_next == S_FIN);
         pe_reset_reg  <= (state_next == S_RST);
         pe_finish_reg <= (state_next == S_FIN);
         busy_reg      <= (state_next != S_IDLE);
         done_reg      <= (state_next == S_DONE);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PE; gi++) begin : g_pe_strobe
         assign PE_reset[gi]  = pe_reset_reg;
         assign PE_finish[gi] = pe_finish_reg;
      end
   endgenerate

   assign cal_start = cal_start_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign pixel_idx = pix_reg;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Table-driven bench for conv_pe_sequencer: each vector is one pass whose expected strobe
// schedule is queued at start and popped cycle by cycle as the DUT runs.
module tb_conv_pe_sequencer;

   localparam int NUM_PE = 16;
   localparam int PIX_W  = 16;
   localparam int ACC_W  = 8;
   localparam int NV     = 7;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic [PIX_W-1:0]  cfg_num_pixels;
   logic [ACC_W-1:0]  cfg_acc_cycles;
   logic              ofm_ready;
   logic              cal_start;
   logic [NUM_PE-1:0] PE_reset;
   logic [NUM_PE-1:0] PE_finish;
   logic              busy;
   logic              done;
   logic [PIX_W-1:0]  pixel_idx;

   conv_pe_sequencer #(
      .NUM_PE(NUM_PE), .START_DELAY(3), .PIX_W(PIX_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_num_pixels(cfg_num_pixels), .cfg_acc_cycles(cfg_acc_cycles),
      .ofm_ready(ofm_ready), .cal_start(cal_start), .PE_reset(PE_reset),
      .PE_finish(PE_finish), .busy(busy), .done(done), .pixel_idx(pixel_idx)
   );

   always #5 clk = ~clk;

   // done_rel / abort_rel count cycles after the edge that accepted start (0 = first busy cycle).
   typedef struct {
      int n;
      int acc;
      int stall_pix;
      int stall_len;
      int abort_rel;
      bit noise;
      int done_rel;
   } vec_t;

   typedef enum int {EV_RST, EV_FIN, EV_DONE} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       rel;
      int       idx;
   } ev_t;

   vec_t vecs [NV];
   ev_t  sb [$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int rel, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at rel %0d: got %0h, expected %0h", name, rel, act, exp);
      end
   endtask

   task automatic run_vec(input int t, input vec_t v);
      int   shift;
      int   r;
      int   f_stall;
      int   last_rel;
      int   cur_idx;
      int   n_rst;
      int   n_fin;
      int   n_done;
      bit   exp_r;
      bit   exp_f;
      bit   exp_d;
      bit   exp_cal;
      ev_t  e;

      // Expected schedule: 3 priming cycles, then one (acc+2)-cycle period per pixel,
      // with the stall length added after the stalled pixel's reset.
      shift = 0;
      for (int p = 0; p < v.n; p++) begin
         r = 3 + p * (v.acc + 2) + shift;
         if (v.abort_rel < 0 || r <= v.abort_rel) sb.push_back('{EV_RST, r, p});
         if (p == v.stall_pix) shift += v.stall_len;
         r = 3 + p * (v.acc + 2) + v.acc + 1 + shift;
         if (v.abort_rel < 0 || r <= v.abort_rel) sb.push_back('{EV_FIN, r, p});
      end
      if (v.abort_rel < 0) sb.push_back('{EV_DONE, v.done_rel, (v.n > 0) ? v.n - 1 : 0});

      f_stall  = 3 + v.stall_pix * (v.acc + 2) + v.acc + 1;
      last_rel = (v.abort_rel >= 0) ? v.abort_rel : v.done_rel;

      cfg_num_pixels = PIX_W'(v.n);
      cfg_acc_cycles = ACC_W'(v.acc);
      ofm_ready      = 1'b1;
      abort          = 1'b0;
      start          = 1'b1;
      @(negedge clk);
      start = 1'b0;

      cur_idx = 0;
      n_rst   = 0;
      n_fin   = 0;
      n_done  = 0;
      for (int rel = 0; rel <= last_rel + 4; rel++) begin
         exp_r = 1'b0;
         exp_f = 1'b0;
         exp_d = 1'b0;
         if (sb.size() > 0 && sb[0].rel == rel) begin
            e = sb.pop_front();
            case (e.kind)
               EV_RST:  begin exp_r = 1'b1; cur_idx = e.idx; end
               EV_FIN:  exp_f = 1'b1;
               default: exp_d = 1'b1;
            endcase
         end
         if (rel > last_rel) cur_idx = 0;
         if (v.abort_rel >= 0) exp_cal = (v.n > 0) && (rel <= v.abort_rel);
         else                  exp_cal = (v.n > 0) && (rel < v.done_rel);

         if (PE_reset != '0)  n_rst++;
         if (PE_finish != '0) n_fin++;
         if (done)            n_done++;

         check("PE_reset",  rel, 32'(PE_reset),  exp_r ? 32'hFFFF : 32'h0);
         check("PE_finish", rel, 32'(PE_finish), exp_f ? 32'hFFFF : 32'h0);
         check("done",      rel, 32'(done),      32'(exp_d));
         check("busy",      rel, 32'(busy),      32'(rel <= last_rel));
         check("cal_start", rel, 32'(cal_start), 32'(exp_cal));
         check("pixel_idx", rel, 32'(pixel_idx), 32'(cur_idx));

         ofm_ready = !(v.stall_pix >= 0 && rel >= f_stall - 1 && rel <= f_stall - 2 + v.stall_len);
         abort     = (rel == v.abort_rel);
         start     = (rel == v.abort_rel) || (v.noise && (rel == 5 || rel == v.done_rel));
         if (v.noise && rel == 5) begin
            cfg_num_pixels = PIX_W'(9);
            cfg_acc_cycles = ACC_W'(20);
         end
         @(negedge clk);
      end
      start     = 1'b0;
      abort     = 1'b0;
      ofm_ready = 1'b1;

      check("events_left", t, 32'(sb.size()), 32'h0);
      check("done_count",  t, 32'(n_done), (v.abort_rel >= 0) ? 32'h0 : 32'h1);
      sb.delete();
      $display("pass %0d: n=%0d acc=%0d stall=%0d/%0d abort=%0d resets=%0d finishes=%0d dones=%0d",
               t, v.n, v.acc, v.stall_pix, v.stall_len, v.abort_rel, n_rst, n_fin, n_done);
   endtask

   initial begin
      //          n  acc stall_pix stall_len abort noise done_rel
      vecs[0] = '{4, 34, -1,  0, -1, 1'b0, 147};  // 3 + 4*36
      vecs[1] = '{2,  4,  0, 10, -1, 1'b0,  25};  // 3 + 2*6 + 10
      vecs[2] = '{0,  5, -1,  0, -1, 1'b0,   0};  // empty pass
      vecs[3] = '{1,  0, -1,  0, -1, 1'b0,   5};  // reset, finish, done back to back
      vecs[4] = '{8,  4, -1,  0, 17, 1'b0,  -1};  // abort in ACC of pixel 2
      vecs[5] = '{3,  2, -1,  0, -1, 1'b1,  15};  // cfg change + stray starts
      vecs[6] = '{2,  1,  1,  3, -1, 1'b0,  12};  // stall on the last pixel

      reset          = 1'b1;
      start          = 1'b1;
      abort          = 1'b0;
      ofm_ready      = 1'b1;
      cfg_num_pixels = PIX_W'(5);
      cfg_acc_cycles = ACC_W'(5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_outputs", i,
               {17'(0), cal_start, busy, done, 12'(0)} | 32'(PE_reset) | 32'(PE_finish) | 32'(pixel_idx),
               32'h0);
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 0, 32'(busy), 32'h0);
      $display("reset: held 3 cycles with start=1, busy=%0b cal_start=%0b", busy, cal_start);

      for (int t = 0; t < NV; t++) begin
         run_vec(t, vecs[t]);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
